// File: rtl/req_index_server.sv
// req_index_server: synchronizes WIDTH request lines, latches rising edges into a sticky
// pending vector and serves them one at a time, highest index first, over valid/ready.
module req_index_server #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned WIDTH_OUT = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     D,
    input  logic                 out_ready,
    input  logic                 clr_drop,
    output logic                 out_valid,
    output logic [WIDTH_OUT-1:0] out_idx,
    output logic [WIDTH-1:0]     pending,
    output logic                 drop_flag,
    output logic [CNT_W-1:0]     serve_cnt
);
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     s1_q, s2_q, s3_q;
    logic [WIDTH-1:0]     pend_q, pend_d;
    logic [WIDTH-1:0]     rise, clr;
    logic [WIDTH_OUT-1:0] idx_q, idx_d, hi_idx;
    logic                 drop_q, drop_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 accept;

    assign rise   = s2_q & ~s3_q;
    assign accept = (state_q == VALID) && out_ready;
    assign clr    = accept ? (WIDTH'(1) << idx_q) : '0;

    // A rise coinciding with the clear of the same bit re-arms it without counting a drop.
    always_comb begin
        pend_d = rise | (pend_q & ~clr);
        drop_d = drop_q;
        if (|(rise & pend_q & ~clr)) begin
            drop_d = 1'b1;
        end else if (clr_drop) begin
            drop_d = 1'b0;
        end
    end

    always_comb begin
        hi_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pend_q[i]) begin
                hi_idx = WIDTH_OUT'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    idx_d   = hi_idx;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= D;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == VALID);
    assign out_idx   = idx_q;
    assign pending   = pend_q;
    assign drop_flag = drop_q;
    assign serve_cnt = cnt_q;
endmodule

// File: tb/tb_req_index_server.sv
// Bench for req_index_server: directed vector table, hand-written corner sequences and
// randomized traffic, all compared against a behavioural model of the serving rules.
module tb_req_index_server;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] D = '0;
    logic       out_ready = 1'b0;
    logic       clr_drop = 1'b0;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic       drop_flag;
    logic [7:0] serve_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    req_index_server #(.WIDTH(8), .WIDTH_OUT(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .D(D), .out_ready(out_ready), .clr_drop(clr_drop),
        .out_valid(out_valid), .out_idx(out_idx), .pending(pending),
        .drop_flag(drop_flag), .serve_cnt(serve_cnt)
    );

    always #5 clk = ~clk;

    // Model: D samples seen 1, 2 and 3 edges ago; a request is born when the 2-ago sample
    // is high and the 3-ago sample was low.
    logic [7:0] m_hist [3];
    logic [7:0] m_pend;
    bit         m_valid;
    int         m_idx;
    bit         m_drop;
    int         m_cnt;
    int         m_hs;

    function automatic int top_bit(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_pend = '0; m_valid = 0; m_idx = 0; m_drop = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [7:0] born, served;
        bit         acc;
        born   = m_hist[1] & ~m_hist[2];
        acc    = m_valid && out_ready;
        served = acc ? (8'b1 << m_idx) : 8'h00;
        if ((born & m_pend & ~served) != 0) m_drop = 1;
        else if (clr_drop) m_drop = 0;
        if (acc) begin
            m_valid = 0;
            m_cnt   = (m_cnt + 1) % 256;
            m_hs++;
        end else if (!m_valid && m_pend != 0) begin
            m_valid = 1;
            m_idx   = top_bit(m_pend);
        end
        m_pend    = born | (m_pend & ~served);
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = D;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("model_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("model_pending", {24'b0, pending}, {24'b0, m_pend});
        check("model_drop", {31'b0, drop_flag}, {31'b0, m_drop});
        check("model_cnt", {24'b0, serve_cnt}, 32'(m_cnt));
        if (m_valid) check("model_idx", {29'b0, out_idx}, 32'(m_idx));
    endtask

    task automatic do_reset();
        rst = 1'b1; D = '0; out_ready = 1'b0; clr_drop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit         new_seq;
        logic [7:0] d;
        bit         rdy;
        bit         e_valid;
        logic [2:0] e_idx;
        logic [7:0] e_pend;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vt [16];

    initial begin
        // single request on line 4
        vt[0]  = '{1, 8'h10, 1, 0, 3'd0, 8'h00, 8'd0};
        vt[1]  = '{0, 8'h10, 1, 0, 3'd0, 8'h00, 8'd0};
        vt[2]  = '{0, 8'h10, 1, 0, 3'd0, 8'h10, 8'd0};
        vt[3]  = '{0, 8'h10, 1, 1, 3'd4, 8'h10, 8'd0};
        vt[4]  = '{0, 8'h10, 1, 0, 3'd0, 8'h00, 8'd1};
        vt[5]  = '{0, 8'h00, 1, 0, 3'd0, 8'h00, 8'd1};
        // simultaneous lines 7, 2, 0
        vt[6]  = '{1, 8'h85, 1, 0, 3'd0, 8'h00, 8'd0};
        vt[7]  = '{0, 8'h85, 1, 0, 3'd0, 8'h00, 8'd0};
        vt[8]  = '{0, 8'h85, 1, 0, 3'd0, 8'h85, 8'd0};
        vt[9]  = '{0, 8'h85, 1, 1, 3'd7, 8'h85, 8'd0};
        vt[10] = '{0, 8'h85, 1, 0, 3'd0, 8'h05, 8'd1};
        vt[11] = '{0, 8'h85, 1, 1, 3'd2, 8'h05, 8'd1};
        vt[12] = '{0, 8'h85, 1, 0, 3'd0, 8'h01, 8'd2};
        vt[13] = '{0, 8'h85, 1, 1, 3'd0, 8'h01, 8'd2};
        vt[14] = '{0, 8'h85, 1, 0, 3'd0, 8'h00, 8'd3};
        vt[15] = '{0, 8'h00, 1, 0, 3'd0, 8'h00, 8'd3};

        m_hs = 0;
        model_reset();

        // T1: reset with random lines, then quiet
        D = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pending", {24'b0, pending}, 32'd0);
        check("rst_drop", {31'b0, drop_flag}, 32'd0);
        check("rst_cnt", {24'b0, serve_cnt}, 32'd0);
        check("rst_idx", {29'b0, out_idx}, 32'd0);
        D = '0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_valid", {31'b0, out_valid}, 32'd0);
        end

        // T2/T3 vector table
        for (int i = 0; i < 16; i++) begin
            if (vt[i].new_seq) do_reset();
            D = vt[i].d;
            out_ready = vt[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vt[i].e_valid});
            check($sformatf("vec%0d_pend", i), {24'b0, pending}, {24'b0, vt[i].e_pend});
            check($sformatf("vec%0d_cnt", i), {24'b0, serve_cnt}, {24'b0, vt[i].e_cnt});
            if (vt[i].e_valid)
                check($sformatf("vec%0d_idx", i), {29'b0, out_idx}, {29'b0, vt[i].e_idx});
        end

        // T4: backpressure, later higher-priority arrival does not preempt
        do_reset();
        D = 8'h08;
        repeat (4) step();
        check("bp_first_valid", {31'b0, out_valid}, 32'd1);
        check("bp_first_idx", {29'b0, out_idx}, 32'd3);
        D = 8'h48;
        repeat (4) step();
        check("bp_stall_valid", {31'b0, out_valid}, 32'd1);
        check("bp_stall_idx", {29'b0, out_idx}, 32'd3);
        check("bp_stall_pend", {24'b0, pending}, 32'h48);
        out_ready = 1'b1;
        step();
        check("bp_acc3_pend", {24'b0, pending}, 32'h40);
        check("bp_acc3_cnt", {24'b0, serve_cnt}, 32'd1);
        step();
        check("bp_next_idx", {29'b0, out_idx}, 32'd6);
        check("bp_next_valid", {31'b0, out_valid}, 32'd1);
        step();
        check("bp_acc6_cnt", {24'b0, serve_cnt}, 32'd2);
        check("bp_acc6_pend", {24'b0, pending}, 32'h00);

        // T5: second edge on a pending line sets drop_flag
        do_reset();
        D = 8'h02; step();
        D = 8'h00; repeat (4) step();
        check("drop_pre", {31'b0, drop_flag}, 32'd0);
        D = 8'h02; step();
        D = 8'h00; repeat (3) step();
        check("drop_set", {31'b0, drop_flag}, 32'd1);
        check("drop_pend", {24'b0, pending}, 32'h02);
        clr_drop = 1'b1; step();
        clr_drop = 1'b0;
        check("drop_clr", {31'b0, drop_flag}, 32'd0);
        check("drop_pend_kept", {24'b0, pending}, 32'h02);
        out_ready = 1'b1;
        repeat (2) step();

        // T6: asynchronous reset while presenting index 5
        do_reset();
        D = 8'h20;
        repeat (4) step();
        check("mid_valid_pre", {31'b0, out_valid}, 32'd1);
        check("mid_idx_pre", {29'b0, out_idx}, 32'd5);
        #3;
        rst = 1'b1;
        #1;
        check("mid_valid_async", {31'b0, out_valid}, 32'd0);
        check("mid_pend_async", {24'b0, pending}, 32'd0);
        model_reset();
        D = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("mid_cnt_after", {24'b0, serve_cnt}, 32'd0);

        // Counter wrap after 256 handshakes
        do_reset();
        out_ready = 1'b1;
        m_hs = 0;
        for (int c = 0; c < 2000 && m_hs < 256; c++) begin
            D = D ^ 8'h01;
            step();
        end
        if (m_hs < 256) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_timeout: got %0d handshakes expected 256", m_hs);
        end
        check("wrap_cnt", {24'b0, serve_cnt}, 32'd0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) D = D ^ (8'b1 << $urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            clr_drop  = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
